// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch-side branch prediction datapath.
//   NOP_INSTR   : canonical RISC-V NOP (addi x0, x0, 0)
//   bht_ctr_t   : 2-bit saturating direction counter, WEAK_NT is its init value
//   btb_entry_t : one BTB entry (valid, tag, target). The tag field is sized for
//                 the smallest legal index width (1 bit); deeper tables store
//                 their narrower tag zero-extended into it.
//   ctr_next()  : saturating counter step
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int BTB_MIN_IW = 1;
  localparam int BTB_TAG_W  = 32 - BTB_MIN_IW - 2;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t WEAK_NT = 2'b01;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
    bht_ctr_t r;
    r = c;
    if (taken && c != 2'b11) r = c + 2'b01;
    else if (!taken && c != 2'b00) r = c - 2'b01;
    return r;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit saturating counters.
//   clk, rst_n        : clock, asynchronous active-low reset (clears valid + counters)
//   lookup_pc         : PC to predict for (combinational lookup)
//   predict_taken     : hit && counter MSB
//   predict_target    : stored target when predict_taken, else 0
//   upd_valid/upd_pc/upd_taken/upd_target : resolved branch report, written at the edge
module branch_predictor
  import riscv_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lookup_pc,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - IW;

  logic [BTB_ENTRIES-1:0] valid_q;
  bht_ctr_t               ctr_q [BTB_ENTRIES];
  logic [TW-1:0]          tag_q [BTB_ENTRIES];
  logic [31:0]            tgt_q [BTB_ENTRIES];

  logic [IW-1:0] lk_idx, up_idx;
  logic [TW-1:0] lk_tag, up_tag;
  btb_entry_t    lk_e, up_e;
  logic          lk_hit, up_hit;
  bht_ctr_t      ctr_base, ctr_d;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx = lookup_pc[IW+1:2];
  assign lk_tag = lookup_pc[31:IW+2];
  assign up_idx = upd_pc[IW+1:2];
  assign up_tag = upd_pc[31:IW+2];

  assign lk_e.valid  = valid_q[lk_idx];
  assign lk_e.tag    = BTB_TAG_W'(tag_q[lk_idx]);
  assign lk_e.target = tgt_q[lk_idx];
  assign up_e.valid  = valid_q[up_idx];
  assign up_e.tag    = BTB_TAG_W'(tag_q[up_idx]);
  assign up_e.target = tgt_q[up_idx];

  assign lk_hit = lk_e.valid && (lk_e.tag == BTB_TAG_W'(lk_tag));
  assign up_hit = up_e.valid && (up_e.tag == BTB_TAG_W'(up_tag));

  assign predict_taken  = lk_hit && ctr_q[lk_idx][1];
  assign predict_target = predict_taken ? lk_e.target : 32'h0;

  // A new (or aliasing) branch starts from weakly-not-taken before this outcome.
  assign ctr_base = up_hit ? ctr_q[up_idx] : WEAK_NT;
  assign ctr_d    = ctr_next(ctr_base, upd_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) ctr_q[i] <= WEAK_NT;
    end else if (upd_valid) begin
      ctr_q[up_idx] <= ctr_d;
      if (upd_taken) valid_q[up_idx] <= 1'b1;
    end
  end

  // Tag/target storage carries no reset; valid_q guards it.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, BTB prediction and
// performance counters, feeding the IF/ID pipeline register.
//   clk, rst_n            : clock, asynchronous active-low reset
//   stall                 : hold PC
//   redirect, redirect_pc : misprediction recovery (highest priority)
//   upd_*                 : predictor training from resolved branches
//   imem_addr / imem_rdata: instruction memory (combinational read)
//   if_*                  : IF/ID payload
//   perf_branches         : number of upd_valid reports
//   perf_mispredicts      : number of redirect cycles
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_predict_taken,
  output logic [31:0] if_predict_target,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] perf_br_q, perf_mis_q;

  branch_predictor #(
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_bp (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_pc     (pc_q),
    .predict_taken (if_predict_taken),
    .predict_target(if_predict_target),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target)
  );

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redirect)              pc_d = redirect_pc;
    else if (stall)            pc_d = pc_q;
    else if (if_predict_taken) pc_d = if_predict_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (upd_valid) perf_br_q  <= perf_br_q + 32'd1;
      if (redirect)  perf_mis_q <= perf_mis_q + 32'd1;
    end
  end

  assign imem_addr        = pc_q;
  assign if_pc            = pc_q;
  assign if_instruction   = imem_rdata;
  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [31:0] imem_addr, imem_rdata, if_pc, if_instruction, if_predict_target;
  logic        if_predict_taken;
  logic [31:0] perf_branches, perf_mispredicts;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  fetch_stage #(
    .RESET_PC   (32'h0000_0100),
    .BTB_ENTRIES(16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .if_pc            (if_pc),
    .if_instruction   (if_instruction),
    .if_predict_taken (if_predict_taken),
    .if_predict_target(if_predict_target),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic [31:0] epc;
    logic        ept;
    logic [31:0] etg;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tg;
    logic [31:0] br;
    logic [31:0] mis;
  } exp_t;

  exp_t sb[$];
  vec_t vt[25];

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utg, input logic [31:0] epc,
                              input logic ept, input logic [31:0] etg);
    vec_t v;
    v.st = st; v.rd = rd; v.rpc = rpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
    v.epc = epc; v.ept = ept; v.etg = etg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; redirect = 0; redirect_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_br, exp_mis;
    exp_t e;

    // Inputs during cycle i, expected outputs after that cycle's edge.
    //          st rd rpc           uv upc           ut utg           epc           ept etg
    vt[0]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h104,      0, 32'h0);
    vt[1]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h108,      0, 32'h0);
    vt[2]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h108,      0, 32'h0);
    vt[3]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h108,      0, 32'h0);
    vt[4]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h108,      0, 32'h0);
    vt[5]  = mk(0, 0, 32'h0,        1, 32'h110,      1, 32'h200,      32'h10C,      0, 32'h0);
    vt[6]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h110,      1, 32'h200);
    vt[7]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h200,      0, 32'h0);
    vt[8]  = mk(1, 0, 32'h0,        1, 32'h110,      0, 32'h0,        32'h200,      0, 32'h0);
    vt[9]  = mk(1, 0, 32'h0,        1, 32'h110,      0, 32'h0,        32'h200,      0, 32'h0);
    vt[10] = mk(0, 1, 32'h110,      0, 32'h0,        0, 32'h0,        32'h110,      0, 32'h0);
    vt[11] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h114,      0, 32'h0);
    vt[12] = mk(0, 0, 32'h0,        1, 32'h118,      1, 32'h400,      32'h118,      1, 32'h400);
    vt[13] = mk(1, 1, 32'h300,      0, 32'h0,        0, 32'h0,        32'h300,      0, 32'h0);
    vt[14] = mk(0, 1, 32'h118,      0, 32'h0,        0, 32'h0,        32'h118,      1, 32'h400);
    vt[15] = mk(1, 1, 32'h300,      1, 32'h120,      1, 32'h700,      32'h300,      0, 32'h0);
    vt[16] = mk(0, 1, 32'h120,      0, 32'h0,        0, 32'h0,        32'h120,      1, 32'h700);
    vt[17] = mk(0, 1, 32'h3F0,      1, 32'h040,      1, 32'h500,      32'h3F0,      0, 32'h0);
    vt[18] = mk(0, 1, 32'h040,      0, 32'h0,        0, 32'h0,        32'h040,      1, 32'h500);
    vt[19] = mk(1, 0, 32'h0,        1, 32'h080,      1, 32'h600,      32'h040,      0, 32'h0);
    vt[20] = mk(0, 1, 32'h080,      0, 32'h0,        0, 32'h0,        32'h080,      1, 32'h600);
    vt[21] = mk(1, 0, 32'h0,        1, 32'h080,      0, 32'h0,        32'h080,      0, 32'h0);
    vt[22] = mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0,       0, 32'h0,        32'hFFFF_FFFC, 0, 32'h0);
    vt[23] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0);
    vt[24] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h4,        0, 32'h0);

    idle_inputs();
    rst_n = 0;
    #12;
    chk("reset_pc", if_pc, 32'h100);
    chk("reset_imem_addr", imem_addr, 32'h100);
    chk("reset_pt", {31'h0, if_predict_taken}, 32'h0);
    chk("reset_ptgt", if_predict_target, 32'h0);
    chk("reset_perf_br", perf_branches, 32'h0);
    chk("reset_perf_mis", perf_mispredicts, 32'h0);

    @(negedge clk);
    rst_n = 1;
    chk("first_fetch", if_pc, 32'h100);

    exp_br = 0;
    exp_mis = 0;
    for (int i = 0; i < 25; i++) begin
      stall = vt[i].st; redirect = vt[i].rd; redirect_pc = vt[i].rpc;
      upd_valid = vt[i].uv; upd_pc = vt[i].upc; upd_taken = vt[i].ut; upd_target = vt[i].utg;
      if (vt[i].uv) exp_br = exp_br + 1;
      if (vt[i].rd) exp_mis = exp_mis + 1;
      e.id = i; e.pc = vt[i].epc; e.pt = vt[i].ept; e.tg = vt[i].etg;
      e.br = exp_br; e.mis = exp_mis;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_pc", e.id), if_pc, e.pc);
        chk($sformatf("v%0d_imem_addr", e.id), imem_addr, e.pc);
        chk($sformatf("v%0d_instr", e.id), if_instruction, e.pc ^ 32'hA5A5_0000);
        chk($sformatf("v%0d_pt", e.id), {31'h0, if_predict_taken}, {31'h0, e.pt});
        chk($sformatf("v%0d_ptgt", e.id), if_predict_target, e.tg);
        chk($sformatf("v%0d_perf_br", e.id), perf_branches, e.br);
        chk($sformatf("v%0d_perf_mis", e.id), perf_mispredicts, e.mis);
      end
    end
    idle_inputs();

    // perf_branches wrap from all-ones
    force dut.perf_br_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_br_q;
    chk("perf_br_preload", perf_branches, 32'hFFFF_FFFF);
    upd_valid = 1; upd_pc = 32'h0; upd_taken = 0;
    @(negedge clk);
    chk("perf_br_wrap", perf_branches, 32'h0);
    upd_valid = 0;

    // Asynchronous reset mid-sequence, with an update pending at the edge
    upd_valid = 1; upd_pc = 32'h130; upd_taken = 1; upd_target = 32'h800;
    #2;
    rst_n = 0;
    #1;
    chk("midrst_pc", if_pc, 32'h100);
    chk("midrst_perf_br", perf_branches, 32'h0);
    chk("midrst_perf_mis", perf_mispredicts, 32'h0);
    chk("midrst_pt", {31'h0, if_predict_taken}, 32'h0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    chk("midrst_hold_pc", if_pc, 32'h100);
    redirect = 1; redirect_pc = 32'h118;
    @(negedge clk);
    chk("midrst_tbl_pc", if_pc, 32'h118);
    chk("midrst_tbl_cleared", {31'h0, if_predict_taken}, 32'h0);
    redirect_pc = 32'h130;
    @(negedge clk);
    chk("midrst_upd_dropped_pc", if_pc, 32'h130);
    chk("midrst_upd_dropped", {31'h0, if_predict_taken}, 32'h0);
    chk("midrst_perf_mis_after", perf_mispredicts, 32'h2);
    idle_inputs();
    @(negedge clk);
    chk("midrst_advance", if_pc, 32'h134);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
